// File: rtl/sr_flag_arbiter_if.sv
// Request/grant bundle between status producers, the flag arbiter and the SR flag bank.
interface sr_flag_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
);
  logic [NREQ-1:0]       req_i;
  logic [NREQ*WIDTH-1:0] set_mask_i;
  logic [NREQ*WIDTH-1:0] clr_mask_i;
  logic [NREQ-1:0]       gnt_o;
  logic [WIDTH-1:0]      s_o;
  logic [WIDTH-1:0]      r_o;
  logic                  conflict_o;
  logic                  busy_o;

  modport master (
    output req_i, set_mask_i, clr_mask_i,
    input  gnt_o, s_o, r_o, conflict_o, busy_o
  );

  modport slave (
    input  req_i, set_mask_i, clr_mask_i,
    output gnt_o, s_o, r_o, conflict_o, busy_o
  );
endinterface

// File: rtl/sr_flag_arbiter.sv
// Round-robin arbiter that turns per-requester set/clear masks into one-cycle
// S/R pulses for a shared SR flag bank, never driving S and R together on a bit.
module sr_flag_arbiter #(
  parameter int NREQ         = 4,
  parameter int WIDTH        = 8,
  parameter bit CONFLICT_SET = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  sr_flag_arbiter_if.slave  bus
);

  localparam int          PTR_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned NREQ_U = NREQ;

  typedef enum logic {ARB, DRIVE} state_t;

  state_t           state, state_next;
  logic [PTR_W-1:0] ptr, ptr_next;
  logic [PTR_W-1:0] win, cand;
  logic             found;
  int unsigned      idx;

  logic [WIDTH-1:0] win_set, win_clr, ov;
  logic [NREQ-1:0]  gnt_q, gnt_next;
  logic [WIDTH-1:0] s_q, s_next, r_q, r_next;
  logic             conflict_q, conflict_next;

  // Rotating priority search: first requester at or after ptr, wrapping to 0.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    cand  = '0;
    for (int unsigned i = 0; i < NREQ_U; i++) begin
      idx = 32'(ptr) + i;
      if (idx >= NREQ_U) idx = idx - NREQ_U;
      cand = PTR_W'(idx);
      if (!found && bus.req_i[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_comb begin
    win_set = bus.set_mask_i[32'(win)*WIDTH +: WIDTH];
    win_clr = bus.clr_mask_i[32'(win)*WIDTH +: WIDTH];
    ov      = win_set & win_clr;
  end

  always_comb begin
    state_next    = state;
    ptr_next      = ptr;
    gnt_next      = '0;
    s_next        = '0;
    r_next        = '0;
    conflict_next = 1'b0;
    case (state)
      ARB: begin
        if (found) begin
          state_next    = DRIVE;
          gnt_next      = NREQ'(1) << win;
          conflict_next = |ov;
          ptr_next      = (win == PTR_W'(NREQ - 1)) ? '0 : win + 1'b1;
          if (CONFLICT_SET) begin
            s_next = win_set;
            r_next = win_clr & ~win_set;
          end else begin
            s_next = win_set & ~ov;
            r_next = win_clr & ~ov;
          end
        end
      end
      DRIVE: state_next = ARB;
      default: state_next = ARB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ARB;
      ptr        <= '0;
      gnt_q      <= '0;
      s_q        <= '0;
      r_q        <= '0;
      conflict_q <= 1'b0;
    end else begin
      state      <= state_next;
      ptr        <= ptr_next;
      gnt_q      <= gnt_next;
      s_q        <= s_next;
      r_q        <= r_next;
      conflict_q <= conflict_next;
    end
  end

  assign bus.gnt_o      = gnt_q;
  assign bus.s_o        = s_q;
  assign bus.r_o        = r_q;
  assign bus.conflict_o = conflict_q;
  assign bus.busy_o     = (state == DRIVE);

endmodule

// File: tb/tb_sr_flag_arbiter.sv
// Directed bench for sr_flag_arbiter: both conflict policies side by side,
// single-request vector table plus round-robin, reset and late-request sequences.
module tb_sr_flag_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic reset;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] set_all, clr_all;

  int errors = 0;
  int checks = 0;
  bit mon_en = 1'b0;
  logic [WIDTH-1:0] bank_q;

  always #5 clk = ~clk;

  sr_flag_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) if0 ();
  sr_flag_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) if1 ();

  assign if0.req_i      = req;
  assign if0.set_mask_i = set_all;
  assign if0.clr_mask_i = clr_all;
  assign if1.req_i      = req;
  assign if1.set_mask_i = set_all;
  assign if1.clr_mask_i = clr_all;

  sr_flag_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .CONFLICT_SET(1'b0)) dut0 (
    .clk(clk), .reset(reset), .bus(if0.slave));
  sr_flag_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .CONFLICT_SET(1'b1)) dut1 (
    .clk(clk), .reset(reset), .bus(if1.slave));

  // Model of the external SR flag bank driven by the hold-policy instance.
  always @(posedge clk) begin
    if (reset) bank_q <= '0;
    else       bank_q <= (bank_q & ~if0.r_o) | if0.s_o;
  end

  always @(negedge clk) begin
    if (mon_en) begin
      checks = checks + 1;
      if ((if0.s_o & if0.r_o) !== '0 || (if1.s_o & if1.r_o) !== '0) begin
        errors = errors + 1;
        $display("FAIL sr_overlap t=%0t s0=%h r0=%h s1=%h r1=%h required no common bits",
                 $time, if0.s_o, if0.r_o, if1.s_o, if1.r_o);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic check_idle(input string name);
    check({name, "_gnt"},  32'(if0.gnt_o) | 32'(if1.gnt_o), 32'h0);
    check({name, "_s"},    32'(if0.s_o) | 32'(if1.s_o), 32'h0);
    check({name, "_r"},    32'(if0.r_o) | 32'(if1.r_o), 32'h0);
    check({name, "_conf"}, 32'(if0.conflict_o | if1.conflict_o), 32'h0);
    check({name, "_busy"}, 32'(if0.busy_o | if1.busy_o), 32'h0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    int unsigned n;
    logic [7:0]  set_m, clr_m;
    logic [3:0]  gnt;
    logic [7:0]  s0, r0, s1, r1;
    logic        conf;
  } vec_t;

  vec_t vecs[6];
  logic [3:0] rr_gnt[5];
  logic [7:0] rr_s[5];
  logic [7:0] rr_r[5];

  initial begin
    vecs[0] = '{1, 8'h0F, 8'h00, 4'b0010, 8'h0F, 8'h00, 8'h0F, 8'h00, 1'b0};
    vecs[1] = '{0, 8'hF0, 8'h30, 4'b0001, 8'hC0, 8'h00, 8'hF0, 8'h00, 1'b1};
    vecs[2] = '{2, 8'h00, 8'h00, 4'b0100, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0};
    vecs[3] = '{3, 8'h3C, 8'hC3, 4'b1000, 8'h3C, 8'hC3, 8'h3C, 8'hC3, 1'b0};
    vecs[4] = '{2, 8'h0F, 8'hFF, 4'b0100, 8'h00, 8'hF0, 8'h0F, 8'hF0, 1'b1};
    vecs[5] = '{0, 8'h55, 8'hAA, 4'b0001, 8'h55, 8'hAA, 8'h55, 8'hAA, 1'b0};
    rr_gnt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    rr_s   = '{8'h11, 8'h22, 8'h44, 8'h88, 8'h11};
    rr_r   = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h80};

    reset   = 1'b1;
    req     = 4'b1111;
    set_all = 32'hFFFF_FFFF;
    clr_all = 32'h0000_FFFF;
    tick();
    mon_en = 1'b1;
    check_idle("reset_c1");
    tick();
    check_idle("reset_c2");
    reset = 1'b0;
    req   = '0;

    foreach (vecs[k]) begin
      req     = '0;
      set_all = '0;
      clr_all = '0;
      req[vecs[k].n] = 1'b1;
      set_all[vecs[k].n*8 +: 8] = vecs[k].set_m;
      clr_all[vecs[k].n*8 +: 8] = vecs[k].clr_m;
      tick();
      check($sformatf("vec%0d_gnt", k),   32'(if0.gnt_o), 32'(vecs[k].gnt));
      check($sformatf("vec%0d_gnt1", k),  32'(if1.gnt_o), 32'(vecs[k].gnt));
      check($sformatf("vec%0d_s0", k),    32'(if0.s_o), 32'(vecs[k].s0));
      check($sformatf("vec%0d_r0", k),    32'(if0.r_o), 32'(vecs[k].r0));
      check($sformatf("vec%0d_s1", k),    32'(if1.s_o), 32'(vecs[k].s1));
      check($sformatf("vec%0d_r1", k),    32'(if1.r_o), 32'(vecs[k].r1));
      check($sformatf("vec%0d_conf", k),  32'(if0.conflict_o), 32'(vecs[k].conf));
      check($sformatf("vec%0d_conf1", k), 32'(if1.conflict_o), 32'(vecs[k].conf));
      check($sformatf("vec%0d_busy", k),  32'(if0.busy_o), 32'h1);
      req     = '0;
      set_all = 32'hDEAD_BEEF;
      clr_all = 32'h1234_5678;
      tick();
      check_idle($sformatf("vec%0d_after", k));
      if (k == 0) check("bank_after_vec0", 32'(bank_q), 32'h0F);
    end

    // Reset to return the rotating pointer to requester 0.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req   = 4'b1111;
    set_all = 32'h8844_2211;
    clr_all = 32'h1020_4080;
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("rr%0d_gnt", k), 32'(if0.gnt_o), 32'(rr_gnt[k]));
      check($sformatf("rr%0d_s", k),   32'(if0.s_o), 32'(rr_s[k]));
      check($sformatf("rr%0d_r", k),   32'(if0.r_o), 32'(rr_r[k]));
      tick();
      check($sformatf("rr%0d_gap", k), 32'(if0.gnt_o | if1.gnt_o), 32'h0);
    end

    // Reset during DRIVE drops the command and restarts priority at 0.
    req = 4'b0100;
    tick();
    check("rst_pre_gnt", 32'(if0.gnt_o), 32'b0100);
    reset = 1'b1;
    tick();
    check_idle("rst_drive");
    reset = 1'b0;
    req   = 4'b0101;
    tick();
    check("rst_first_gnt", 32'(if0.gnt_o), 32'b0001);
    check("rst_first_s",   32'(if0.s_o), 32'h11);
    req = 4'b0100;
    tick();
    check_idle("rst_gap");
    tick();
    check("rst_second_gnt", 32'(if0.gnt_o), 32'b0100);
    req = '0;
    tick();

    // A request that appears only during DRIVE waits for the next ARB edge.
    req = 4'b0001;
    tick();
    check("late_req0_gnt", 32'(if0.gnt_o), 32'b0001);
    req = 4'b1000;
    tick();
    check_idle("late_in_drive");
    tick();
    check("late_req3_gnt", 32'(if0.gnt_o), 32'b1000);
    check("late_req3_s",   32'(if0.s_o), 32'h88);
    check("late_req3_r",   32'(if0.r_o), 32'h10);
    req = '0;
    tick();
    check_idle("final");
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
